// File: rtl/mux2x4_scan.sv
// Scanner for a dual 1-of-4 mux: steps SEL through 00..11, waits SETTLE cycles per code,
// and rebuilds both 4-bit source words from the lane outputs for a start/valid/ack consumer.
module mux2x4_scan #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       b0,
    input  logic       b1,
    input  logic       ack,
    output logic [0:1] sel,
    output logic       en,
    output logic       busy,
    output logic       valid,
    output logic [0:3] q0,
    output logic [0:3] q1
);

    localparam logic [3:0] RELOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] phase, phase_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [0:3] q0_nxt, q1_nxt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            phase <= '0;
            cnt   <= '0;
            q0    <= '0;
            q1    <= '0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            cnt   <= cnt_nxt;
            q0    <= q0_nxt;
            q1    <= q1_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase;
        cnt_nxt   = cnt;
        q0_nxt    = q0;
        q1_nxt    = q1;
        sel       = 2'b00;
        en        = 1'b0;
        busy      = 1'b0;
        valid     = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SCAN;
                    phase_nxt = 2'd0;
                    cnt_nxt   = RELOAD;
                end
            end
            SCAN: begin
                en   = 1'b1;
                busy = 1'b1;
                sel  = phase;
                if (cnt != 4'd0) begin
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    // Sample only at the end of the settle window so lagging mux outputs are not captured stale
                    q0_nxt[phase] = b0;
                    q1_nxt[phase] = b1;
                    if (phase == 2'd3) begin
                        state_nxt = DONE;
                    end else begin
                        phase_nxt = phase + 2'd1;
                        cnt_nxt   = RELOAD;
                    end
                end
            end
            DONE: begin
                valid = 1'b1;
                if (ack) begin
                    if (start) begin
                        state_nxt = SCAN;
                        phase_nxt = 2'd0;
                        cnt_nxt   = RELOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mux2x4_scan.sv
// Bench for mux2x4_scan: two instances (SETTLE=1 with an ideal mux, SETTLE=3 with a 2-cycle lagging mux),
// directed vectors push expected results into per-instance queues that monitors pop when VALID rises.
module tb_mux2x4_scan;

    localparam int SETTLE_A = 1;
    localparam int SETTLE_B = 3;

    typedef struct {
        logic [0:3] q0;
        logic [0:3] q1;
        int         cycle;
    } exp_t;

    logic       clk;
    logic       reset_n;
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;

    logic       start_a, ack_a, b0_a, b1_a, en_a, busy_a, valid_a;
    logic [0:1] sel_a;
    logic [0:3] q0_a, q1_a, d0_a, d1_a;

    logic       start_b, ack_b, b0_b, b1_b, en_b, busy_b, valid_b;
    logic [0:1] sel_b, sel_b_d1, sel_b_d2;
    logic       en_b_d1, en_b_d2;
    logic [0:3] q0_b, q1_b, d0_b, d1_b;

    exp_t exp_a[$];
    exp_t exp_b[$];
    logic valid_a_prev = 1'b0;
    logic valid_b_prev = 1'b0;

    mux2x4_scan #(.SETTLE(SETTLE_A)) dut_a (
        .clk(clk), .reset_n(reset_n), .start(start_a), .b0(b0_a), .b1(b1_a), .ack(ack_a),
        .sel(sel_a), .en(en_a), .busy(busy_a), .valid(valid_a), .q0(q0_a), .q1(q1_a)
    );

    mux2x4_scan #(.SETTLE(SETTLE_B)) dut_b (
        .clk(clk), .reset_n(reset_n), .start(start_b), .b0(b0_b), .b1(b1_b), .ack(ack_b),
        .sel(sel_b), .en(en_b), .busy(busy_b), .valid(valid_b), .q0(q0_b), .q1(q1_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign b0_a = en_a ? d0_a[sel_a] : 1'b0;
    assign b1_a = en_a ? d1_a[sel_a] : 1'b0;

    // The second mux only reflects a new select code two cycles after it is driven
    always @(posedge clk) begin
        sel_b_d1 <= sel_b;
        sel_b_d2 <= sel_b_d1;
        en_b_d1  <= en_b;
        en_b_d2  <= en_b_d1;
    end
    assign b0_b = en_b_d2 ? d0_b[sel_b_d2] : 1'b0;
    assign b1_b = en_b_d2 ? d1_b[sel_b_d2] : 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input bit which, input logic [0:3] d0, input logic [0:3] d1);
        exp_t e;
        e.q0 = d0;
        e.q1 = d1;
        if (!which) begin
            d0_a    = d0;
            d1_a    = d1;
            start_a = 1'b1;
            e.cycle = cyc + 1 + 4 * SETTLE_A;
            exp_a.push_back(e);
        end else begin
            d0_b    = d0;
            d1_b    = d1;
            start_b = 1'b1;
            e.cycle = cyc + 1 + 4 * SETTLE_B;
            exp_b.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (valid_a && !valid_a_prev) begin
            if (exp_a.size() == 0) begin
                checkOutput("a_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_a.pop_front();
                checkOutput("a_q0", 32'(q0_a), 32'(e.q0));
                checkOutput("a_q1", 32'(q1_a), 32'(e.q1));
                checkOutput("a_valid_cycle", cyc, e.cycle);
            end
        end
        valid_a_prev = valid_a;
    end

    always @(negedge clk) begin
        if (valid_b && !valid_b_prev) begin
            if (exp_b.size() == 0) begin
                checkOutput("b_unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_b.pop_front();
                checkOutput("b_q0", 32'(q0_b), 32'(e.q0));
                checkOutput("b_q1", 32'(q1_b), 32'(e.q1));
                checkOutput("b_valid_cycle", cyc, e.cycle);
            end
        end
        valid_b_prev = valid_b;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        start_a = 1'b0; ack_a = 1'b0; d0_a = '0; d1_a = '0;
        start_b = 1'b0; ack_b = 1'b0; d0_b = '0; d1_b = '0;
        repeat (2) @(negedge clk);

        checkOutput("rst_sel", 32'(sel_a), 32'd0);
        checkOutput("rst_en", 32'(en_a), 32'd0);
        checkOutput("rst_busy", 32'(busy_a), 32'd0);
        checkOutput("rst_valid", 32'(valid_a), 32'd0);
        checkOutput("rst_q0", 32'(q0_a), 32'd0);
        checkOutput("rst_q1", 32'(q1_a), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Basic scan, with a START pulse mid-scan that must not be remembered
        applyStimulus(1'b0, 4'b1010, 4'b0110);
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput("scan_sel", 32'(sel_a), k);
            checkOutput("scan_en", 32'(en_a), 32'd1);
            if (k == 1) start_a = 1'b1;
            if (k == 2) start_a = 1'b0;
            @(negedge clk);
        end
        checkOutput("done_en", 32'(en_a), 32'd0);
        checkOutput("done_busy", 32'(busy_a), 32'd0);
        checkOutput("done_sel", 32'(sel_a), 32'd0);
        checkOutput("done_valid", 32'(valid_a), 32'd1);

        d0_a = 4'b0000;
        d1_a = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkOutput("hold_valid", 32'(valid_a), 32'd1);
            checkOutput("hold_q0", 32'(q0_a), 32'b1010);
            checkOutput("hold_q1", 32'(q1_a), 32'b0110);
        end
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        checkOutput("ack_valid", 32'(valid_a), 32'd0);
        checkOutput("ack_busy", 32'(busy_a), 32'd0);
        checkOutput("ack_q0_kept", 32'(q0_a), 32'b1010);
        @(negedge clk);
        checkOutput("no_queued_start", 32'(busy_a), 32'd0);

        // Lagging mux at SETTLE=3
        applyStimulus(1'b1, 4'b1100, 4'b0011);
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 30 && !valid_b; i++) @(negedge clk);
        checkOutput("b_valid_timeout", 32'(valid_b), 32'd1);
        ack_b = 1'b1;
        @(negedge clk);
        ack_b = 1'b0;
        checkOutput("b_ack_valid", 32'(valid_b), 32'd0);

        // Back-to-back scans with ACK and START held high
        ack_a = 1'b1;
        applyStimulus(1'b0, 4'b0001, 4'b1000);
        repeat (5) @(negedge clk);
        checkOutput("b2b_valid1", 32'(valid_a), 32'd1);
        applyStimulus(1'b0, 4'b1111, 4'b0000);
        @(negedge clk);
        checkOutput("b2b_gap_valid", 32'(valid_a), 32'd0);
        checkOutput("b2b_gap_busy", 32'(busy_a), 32'd1);
        checkOutput("b2b_gap_sel", 32'(sel_a), 32'd0);
        repeat (4) @(negedge clk);
        checkOutput("b2b_valid2", 32'(valid_a), 32'd1);
        start_a = 1'b0;
        @(negedge clk);
        ack_a = 1'b0;
        checkOutput("b2b_end_valid", 32'(valid_a), 32'd0);
        checkOutput("b2b_end_busy", 32'(busy_a), 32'd0);

        // Reset during phase 2, with START on the reset edge
        d0_a = 4'b0011;
        d1_a = 4'b1100;
        start_a = 1'b1;
        repeat (3) @(negedge clk);
        start_a = 1'b0;
        checkOutput("mid_sel", 32'(sel_a), 32'd2);
        reset_n = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        start_a = 1'b0;
        checkOutput("midrst_sel", 32'(sel_a), 32'd0);
        checkOutput("midrst_en", 32'(en_a), 32'd0);
        checkOutput("midrst_busy", 32'(busy_a), 32'd0);
        checkOutput("midrst_valid", 32'(valid_a), 32'd0);
        checkOutput("midrst_q0", 32'(q0_a), 32'd0);
        checkOutput("midrst_q1", 32'(q1_a), 32'd0);
        @(negedge clk);
        checkOutput("midrst_idle", 32'(busy_a), 32'd0);

        applyStimulus(1'b0, 4'b0101, 4'b1010);
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("fresh_valid", 32'(valid_a), 32'd1);
        ack_a = 1'b1;
        @(negedge clk);
        ack_a = 1'b0;
        repeat (2) @(negedge clk);

        checkOutput("a_pending", exp_a.size(), 32'd0);
        checkOutput("b_pending", exp_b.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mux2x4_scan.md
# mux2x4_scan

Sequential scanner that drives the select and enable inputs of a dual 1-of-4 mux and samples its two outputs over all four select codes. It rebuilds the two 4-bit source words that sit behind the mux. It sits on the consumer side of a mux2x4 and lets a control sequencer read back both 4-bit fields with a single start/valid/ack exchange. The settle time per select code is programmable to cover mux and wiring propagation.

## Interface
- SETTLE, default 1: cycles each SEL code is held before the sample; legal range 1..15.
- CLK  in  1  sole clock; all state changes on its rising edge.
- RESET_N  in  1  reset, synchronous and active-low.
- START  in  1  scan request; sampled only in IDLE, or in DONE together with ACK.
- B0  in  1  mux lane-0 output.
- B1  in  1  mux lane-1 output.
- ACK  in  1  consumer accepts Q0/Q1; meaningful only while VALID=1.
- SEL  out  [0:1]  select code driven to the mux.
- EN  out  1  mux enable; 1 only while scanning.
- BUSY  out  1  scan in progress.
- VALID  out  1  Q0/Q1 hold a complete scan result.
- Q0  out  [0:3]  Q0[k] = B0 sampled while SEL=k.
- Q1  out  [0:3]  Q1[k] = B1 sampled while SEL=k.

## Operation
- States: IDLE, SCAN, DONE. The design also keeps a 2-bit phase index (= SEL) and a 4-bit settle counter.
- Reset, applied at any edge with RESET_N=0 and regardless of state, sets:
  - state=IDLE
  - SEL=00, EN=0, BUSY=0, VALID=0
  - Q0=0000, Q1=0000
  - settle counter=0
- IDLE:
  - Outputs: EN=0, SEL=00, BUSY=0, VALID=0.
  - START=1 moves to SCAN with phase=0, counter=SETTLE-1, SEL=00, EN=1, BUSY=1.
- SCAN:
  - EN=1, BUSY=1, SEL=phase.
  - Counter>0: decrement the counter.
  - Counter=0: on that edge, write B0 into Q0[phase] and B1 into Q1[phase].
  - If phase<3 at that edge: phase+1, counter reloads to SETTLE-1.
  - If phase=3 at that edge: go to DONE.
- Phase order is fixed at 00, 01, 10, 11. Q bits not being sampled hold their value.
- DONE:
  - Outputs: VALID=1, BUSY=0, EN=0, SEL=00.
  - Q0/Q1 stay stable until the next scan overwrites them.
  - ACK=0: stay in DONE.
  - ACK=1, START=0: go to IDLE.
  - ACK=1, START=1: go straight to SCAN (back-to-back scan, phase=0, counter reloaded).
- START in SCAN is ignored and is not queued.
- ACK outside DONE is ignored.
- Q0/Q1 keep the last result after ACK. During a new scan they update bit by bit as phases complete.
- No arithmetic beyond the phase increment (wraps 3→done, never to 0 in place) and the counter decrement (never below 0).

## Timing
- The edge that accepts START is E0. SEL=00 and EN=1 are visible in the cycle after E0.
- The sample for phase k happens at edge E0+(k+1)*SETTLE. SEL=k is held for exactly SETTLE cycles ending at that edge.
- VALID=1 from edge E0+4*SETTLE. SETTLE=1 gives 4 cycles START→VALID; SETTLE=3 gives 12 cycles.
- EN falls and SEL returns to 00 on the same edge that VALID rises.
- VALID falls on the edge where ACK=1 is sampled.
- For a back-to-back scan, BUSY=1 and SEL=00 on that same edge, with no IDLE bubble. Throughput is one result per 4*SETTLE+1 cycles when ACK is tied high and START is held.
- RESET_N=0 mid-scan: the next edge gives all reset values, including Q cleared. A START seen on that same edge is ignored.

## Test plan
- Mux model with D0=1010, D1=0110, SETTLE=1, one-cycle START:
  - SEL sequence is 00,01,10,11.
  - VALID=1 four cycles after START with Q0=1010, Q1=0110.
  - EN=0 from then on.
- SETTLE=3 and a mux model whose output lags SEL by 2 cycles, D0=1100, D1=0011:
  - Q0=1100, Q1=0011 with no stale-bit corruption.
  - VALID at cycle 12.
- Hold ACK=0 for 10 cycles after VALID, and pulse START during the scan:
  - VALID, Q0 and Q1 stay constant.
  - The mid-scan START has no effect.
  - ACK=1 drops VALID on the next edge.
- ACK=1 and START=1 held continuously, D0/D1 changed between scans (0001/1000, then 1111/0000):
  - Results alternate correctly.
  - VALID pulses once per 5 cycles at SETTLE=1.
- RESET_N=0 for one cycle during phase 2:
  - Next edge: SEL=00, EN=0, BUSY=0, VALID=0, Q0=Q1=0000.
  - A fresh START then completes normally.
